// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IFU, LSU and memory-port signals shared by the arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_err;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;

    // environment side: requesters and memory model
    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

    // arbiter side
    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IFU/LSU sharing of one memory port, one outstanding transaction, response timeout
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
    logic [DW-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic          ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
    logic          gnt_ifu, gnt_lsu, tout;
    logic [DW-1:0] rdata_n;

    // on a tie the requester that did not win last time gets the port
    always_comb begin
        gnt_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_q);
        gnt_ifu = bus.ifu_req_valid && !gnt_lsu;
    end

    assign bus.ifu_req_ready  = (state_q == IDLE) && gnt_ifu;
    assign bus.lsu_req_ready  = (state_q == IDLE) && gnt_lsu;
    assign bus.mem_req_valid  = (state_q == ISSUE);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    assign bus.ifu_resp_valid = ifu_rv_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_err        = ifu_err_q;
    assign bus.lsu_resp_valid = lsu_rv_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_err        = lsu_err_q;

    // next state, payload capture, timeout counting and response generation
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        ifu_rv_d    = 1'b0;
        ifu_rdata_d = '0;
        ifu_err_d   = 1'b0;
        lsu_rv_d    = 1'b0;
        lsu_rdata_d = '0;
        lsu_err_d   = 1'b0;
        tout        = (cnt_q == 16'(TIMEOUT - 1));
        rdata_n     = (bus.mem_resp_valid && !wen_q) ? bus.mem_rdata : '0;
        case (state_q)
            IDLE: if (gnt_ifu || gnt_lsu) begin
                owner_d = gnt_lsu;
                last_d  = gnt_lsu;
                addr_d  = gnt_lsu ? bus.lsu_addr : bus.ifu_addr;
                wen_d   = gnt_lsu && bus.lsu_wen;
                wdata_d = gnt_lsu ? bus.lsu_wdata : '0;
                wmask_d = (gnt_lsu && bus.lsu_wen) ? bus.lsu_wmask : 4'b0;
                state_d = ISSUE;
            end
            ISSUE: if (bus.mem_req_ready) begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.mem_resp_valid || tout) begin
                ifu_rv_d    = !owner_q;
                ifu_rdata_d = owner_q ? '0 : rdata_n;
                ifu_err_d   = !owner_q && !bus.mem_resp_valid;
                lsu_rv_d    = owner_q;
                lsu_rdata_d = owner_q ? rdata_n : '0;
                lsu_err_d   = owner_q && !bus.mem_resp_valid;
                state_d     = IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= 4'b0;
            cnt_q       <= '0;
            ifu_rv_q    <= 1'b0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_rv_q    <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            ifu_rv_q    <= ifu_rv_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_rv_q    <= lsu_rv_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, stores, timeout and reset
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) b2 ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        b1.ifu_req_valid = 0; b1.ifu_addr = 0; b1.lsu_req_valid = 0; b1.lsu_addr = 0;
        b1.lsu_wen = 0; b1.lsu_wdata = 0; b1.lsu_wmask = 0;
        b1.mem_req_ready = 0; b1.mem_resp_valid = 0; b1.mem_rdata = 0;
        b2.ifu_req_valid = 0; b2.ifu_addr = 0; b2.lsu_req_valid = 0; b2.lsu_addr = 0;
        b2.lsu_wen = 0; b2.lsu_wdata = 0; b2.lsu_wmask = 0;
        b2.mem_req_ready = 0; b2.mem_resp_valid = 0; b2.mem_rdata = 0;
        step(); step();
        rst = 0;
        chk("rst_mem_valid", b1.mem_req_valid, 0);
        chk("rst_ifu_ready", b1.ifu_req_ready, 0);
        chk("rst_lsu_ready", b1.lsu_req_ready, 0);
        chk("rst_ifu_rv", b1.ifu_resp_valid, 0);
        chk("rst_lsu_rv", b1.lsu_resp_valid, 0);
        chk("rst_mem_addr", b1.mem_addr, 0);

        // IFU only, minimum latency
        b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_0000; #1;
        chk("ifu_ready", b1.ifu_req_ready, 1);
        chk("ifu_lsu_ready", b1.lsu_req_ready, 0);
        step();
        b1.ifu_req_valid = 0;
        chk("ifu_mem_valid", b1.mem_req_valid, 1);
        chk("ifu_mem_addr", b1.mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen", b1.mem_wen, 0);
        chk("ifu_mem_wmask", b1.mem_wmask, 0);
        b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0;
        chk("ifu_wait_valid", b1.mem_req_valid, 0);
        b1.mem_resp_valid = 1; b1.mem_rdata = 32'h0010_0073;
        step();
        b1.mem_resp_valid = 0;
        chk("ifu_rv", b1.ifu_resp_valid, 1);
        chk("ifu_rdata", b1.ifu_rdata, 32'h0010_0073);
        chk("ifu_err", b1.ifu_err, 0);
        chk("ifu_lsu_rv", b1.lsu_resp_valid, 0);
        chk("ifu_lsu_rdata", b1.lsu_rdata, 0);
        step();
        chk("ifu_rv_drop", b1.ifu_resp_valid, 0);
        chk("ifu_rdata_drop", b1.ifu_rdata, 0);

        // tie after reset: LSU first, then IFU in the response cycle, then LSU again
        rst = 1; step(); rst = 0;
        b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_0004;
        b1.lsu_req_valid = 1; b1.lsu_addr = 32'h8000_0200; b1.lsu_wen = 0; b1.lsu_wmask = 4'hF; #1;
        chk("tie1_lsu_ready", b1.lsu_req_ready, 1);
        chk("tie1_ifu_ready", b1.ifu_req_ready, 0);
        step();
        b1.lsu_req_valid = 0;
        chk("tie1_mem_addr", b1.mem_addr, 32'h8000_0200);
        chk("tie1_load_wmask", b1.mem_wmask, 0);
        chk("tie1_issue_ifu_ready", b1.ifu_req_ready, 0);
        b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0; b1.mem_resp_valid = 1; b1.mem_rdata = 32'h1122_3344;
        step();
        b1.mem_resp_valid = 0;
        chk("tie1_lsu_rv", b1.lsu_resp_valid, 1);
        chk("tie1_lsu_rdata", b1.lsu_rdata, 32'h1122_3344);
        chk("tie1_ifu_rv", b1.ifu_resp_valid, 0);
        chk("tie2_ifu_ready", b1.ifu_req_ready, 1);
        step();
        b1.ifu_req_valid = 0;
        chk("tie2_mem_addr", b1.mem_addr, 32'h8000_0004);
        b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0; b1.mem_resp_valid = 1; b1.mem_rdata = 32'hAAAA_5555;
        step();
        b1.mem_resp_valid = 0;
        chk("tie2_ifu_rv", b1.ifu_resp_valid, 1);
        chk("tie2_ifu_rdata", b1.ifu_rdata, 32'hAAAA_5555);
        b1.ifu_req_valid = 1; b1.lsu_req_valid = 1; #1;
        chk("tie3_lsu_ready", b1.lsu_req_ready, 1);
        chk("tie3_ifu_ready", b1.ifu_req_ready, 0);
        b1.ifu_req_valid = 0; b1.lsu_req_valid = 0;

        // store with memory stalling for 3 cycles
        b1.lsu_req_valid = 1; b1.lsu_wen = 1; b1.lsu_addr = 32'h8000_0100;
        b1.lsu_wdata = 32'hDEAD_BEEF; b1.lsu_wmask = 4'b0011; #1;
        chk("st_ready", b1.lsu_req_ready, 1);
        step();
        b1.lsu_req_valid = 0; b1.lsu_wdata = 32'h0; b1.lsu_wmask = 4'h0; b1.lsu_addr = 0;
        for (int i = 0; i < 3; i++) begin
            chk("st_stall_valid", b1.mem_req_valid, 1);
            chk("st_stall_addr", b1.mem_addr, 32'h8000_0100);
            chk("st_stall_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
            step();
        end
        chk("st_mem_valid", b1.mem_req_valid, 1);
        chk("st_mem_wen", b1.mem_wen, 1);
        chk("st_mem_wmask", b1.mem_wmask, 4'b0011);
        b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0; b1.mem_resp_valid = 1; b1.mem_rdata = 32'h1234_5678;
        step();
        b1.mem_resp_valid = 0; b1.lsu_wen = 0;
        chk("st_lsu_rv", b1.lsu_resp_valid, 1);
        chk("st_lsu_rdata", b1.lsu_rdata, 0);
        chk("st_lsu_err", b1.lsu_err, 0);

        // timeout after exactly 4 WAIT cycles
        b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_0008;
        step();
        b1.ifu_req_valid = 0; b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_rv", b1.ifu_resp_valid, 0);
            step();
        end
        chk("to_rv", b1.ifu_resp_valid, 1);
        chk("to_err", b1.ifu_err, 1);
        chk("to_rdata", b1.ifu_rdata, 0);
        b1.mem_resp_valid = 1; b1.mem_rdata = 32'h5555_AAAA;
        step();
        b1.mem_resp_valid = 0;
        chk("to_stray_rv", b1.ifu_resp_valid, 0);
        chk("to_err_drop", b1.ifu_err, 0);
        step();
        chk("to_stray_rv2", b1.ifu_resp_valid, 0);

        // reset while waiting for the response
        b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_000C;
        step();
        b1.ifu_req_valid = 0; b1.mem_req_ready = 1;
        step();
        b1.mem_req_ready = 0; rst = 1;
        step();
        rst = 0;
        chk("rw_mem_valid", b1.mem_req_valid, 0);
        chk("rw_mem_addr", b1.mem_addr, 0);
        chk("rw_ifu_rv", b1.ifu_resp_valid, 0);
        b1.mem_resp_valid = 1; b1.mem_rdata = 32'h7777_7777;
        step();
        b1.mem_resp_valid = 0;
        chk("rw_stray_ifu", b1.ifu_resp_valid, 0);
        chk("rw_stray_lsu", b1.lsu_resp_valid, 0);
        b1.ifu_req_valid = 1; b1.ifu_addr = 32'h8000_0010; #1;
        chk("rw_new_ready", b1.ifu_req_ready, 1);
        step();
        b1.ifu_req_valid = 0; b1.mem_req_ready = 1;
        chk("rw_new_addr", b1.mem_addr, 32'h8000_0010);
        step();
        b1.mem_req_ready = 0; b1.mem_resp_valid = 1; b1.mem_rdata = 32'hCAFE_F00D;
        step();
        b1.mem_resp_valid = 0;
        chk("rw_new_rv", b1.ifu_resp_valid, 1);
        chk("rw_new_rdata", b1.ifu_rdata, 32'hCAFE_F00D);

        // TIMEOUT=2: response on the 2nd WAIT cycle beats the timeout
        b2.ifu_req_valid = 1; b2.ifu_addr = 32'h8000_0020;
        step();
        b2.ifu_req_valid = 0; b2.mem_req_ready = 1;
        step();
        b2.mem_req_ready = 0;
        step();
        chk("race_wait_rv", b2.ifu_resp_valid, 0);
        b2.mem_resp_valid = 1; b2.mem_rdata = 32'h0BAD_CAFE;
        step();
        b2.mem_resp_valid = 0;
        chk("race_rv", b2.ifu_resp_valid, 1);
        chk("race_err", b2.ifu_err, 0);
        chk("race_rdata", b2.ifu_rdata, 32'h0BAD_CAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
